// File: rtl/pmux_rr_arbiter_pkg.sv
// Shared definitions for the pmux round-robin arbiter.
//   - state_e     : arbiter FSM state (IDLE / OWN)
//   - NUM_REQ     : number of requesters sharing the mux
//   - NUM_SRC     : number of mux data sources
//   - *_IDX_W     : index widths derived from the counts above
//   - BEAT_W      : beat counter width
//   - BURST_MIN/MAX : legal range of the BURST parameter
package pmux_rr_arbiter_pkg;

  localparam int NUM_REQ   = 4;
  localparam int NUM_SRC   = 8;
  localparam int REQ_IDX_W = 2;
  localparam int SRC_IDX_W = 3;
  localparam int BEAT_W    = 4;
  localparam int BURST_MIN = 1;
  localparam int BURST_MAX = 15;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

endpackage

// File: rtl/pmux_rr_arbiter_if.sv
// Bus bundle between the four requesters / data sources and the arbiter.
//   req_k_i   : request from requester k (held until done)
//   src_k_i   : source index requested by requester k
//   data_k_i  : mux data sources 0..7, WIDTH bits each
//   gnt_k_o   : grant to requester k (one-hot or zero)
//   q_o       : selected word, q_valid_o marks a transfer result
//   q_id_o    : requester owning q_o
//   busy_o    : arbiter currently owned
// Modport master = requester/source side, slave = arbiter side.
interface pmux_rr_arbiter_if
  import pmux_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
);

  logic                 req_0_i, req_1_i, req_2_i, req_3_i;
  logic [SRC_IDX_W-1:0] src_0_i, src_1_i, src_2_i, src_3_i;
  logic [WIDTH-1:0]     data_0_i, data_1_i, data_2_i, data_3_i;
  logic [WIDTH-1:0]     data_4_i, data_5_i, data_6_i, data_7_i;
  logic                 gnt_0_o, gnt_1_o, gnt_2_o, gnt_3_o;
  logic [WIDTH-1:0]     q_o;
  logic                 q_valid_o;
  logic [REQ_IDX_W-1:0] q_id_o;
  logic                 busy_o;

  modport master (
    output req_0_i, req_1_i, req_2_i, req_3_i,
    output src_0_i, src_1_i, src_2_i, src_3_i,
    output data_0_i, data_1_i, data_2_i, data_3_i,
    output data_4_i, data_5_i, data_6_i, data_7_i,
    input  gnt_0_o, gnt_1_o, gnt_2_o, gnt_3_o,
    input  q_o, q_valid_o, q_id_o, busy_o
  );

  modport slave (
    input  req_0_i, req_1_i, req_2_i, req_3_i,
    input  src_0_i, src_1_i, src_2_i, src_3_i,
    input  data_0_i, data_1_i, data_2_i, data_3_i,
    input  data_4_i, data_5_i, data_6_i, data_7_i,
    output gnt_0_o, gnt_1_o, gnt_2_o, gnt_3_o,
    output q_o, q_valid_o, q_id_o, busy_o
  );

endinterface

// File: rtl/pmux_rr_pick.sv
// Combinational 4-way rotating priority picker.
//   req_i    : request vector
//   rr_ptr_i : index with highest priority this scan
//   found_o  : at least one request present
//   idx_o    : first requesting index at or after rr_ptr_i (mod 4)
module pmux_rr_pick
  import pmux_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [REQ_IDX_W-1:0] rr_ptr_i,
  output logic                 found_o,
  output logic [REQ_IDX_W-1:0] idx_o
);

  logic [REQ_IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester wins last.
  // The 2-bit candidate wraps naturally modulo 4.
  always_comb begin
    found_o = 1'b0;
    idx_o   = rr_ptr_i;
    cand    = rr_ptr_i;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = rr_ptr_i + REQ_IDX_W'(i);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/pmux_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 WIDTH-bit mux between four requesters.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : slave side of pmux_rr_arbiter_if (requests, source indices,
//           data sources in; grants, registered word, tag, busy out)
// The owner transfers one word per cycle while it requests; ownership rotates
// after BURST transfers (legal 1..15) or when the owner drops its request.
module pmux_rr_arbiter
  import pmux_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BURST = 4
)(
  input logic               clk_i,
  input logic               rst_i,
  pmux_rr_arbiter_if.slave  bus
);

  logic [NUM_REQ-1:0]   req;
  logic [SRC_IDX_W-1:0] src  [NUM_REQ];
  logic [WIDTH-1:0]     data [NUM_SRC];

  state_e               state_q, state_d;
  logic [REQ_IDX_W-1:0] owner_q, owner_d;
  logic [REQ_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0]    beat_q, beat_d, beat_inc;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 q_valid_q, q_valid_d;
  logic [REQ_IDX_W-1:0] q_id_q, q_id_d;

  logic                 release_own;
  logic                 found;
  logic [REQ_IDX_W-1:0] pick_idx, pick_ptr;

  assign req     = {bus.req_3_i, bus.req_2_i, bus.req_1_i, bus.req_0_i};
  assign src[0]  = bus.src_0_i;
  assign src[1]  = bus.src_1_i;
  assign src[2]  = bus.src_2_i;
  assign src[3]  = bus.src_3_i;
  assign data[0] = bus.data_0_i;
  assign data[1] = bus.data_1_i;
  assign data[2] = bus.data_2_i;
  assign data[3] = bus.data_3_i;
  assign data[4] = bus.data_4_i;
  assign data[5] = bus.data_5_i;
  assign data[6] = bus.data_6_i;
  assign data[7] = bus.data_7_i;

  // In OWN the picker is only consulted on release, and a release always
  // rescans starting just after the current owner.
  assign pick_ptr = (state_q == OWN) ? owner_q + 2'd1 : rr_ptr_q;

  pmux_rr_pick u_pick (
    .req_i    (req),
    .rr_ptr_i (pick_ptr),
    .found_o  (found),
    .idx_o    (pick_idx)
  );

  assign beat_inc = beat_q + BEAT_W'(1);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    beat_d      = beat_q;
    q_d         = q_q;
    q_id_d      = q_id_q;
    q_valid_d   = 1'b0;
    release_own = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWN;
          owner_d = pick_idx;
          beat_d  = '0;
        end
      end
      OWN: begin
        if (!req[owner_q]) begin
          release_own = 1'b1;
        end else begin
          q_d       = data[src[owner_q]];
          q_id_d    = owner_q;
          q_valid_d = 1'b1;
          beat_d    = beat_inc;
          if (beat_inc == BEAT_W'(BURST)) release_own = 1'b1;
        end
        // Hand over without a bubble; a lone owner wraps back to itself.
        if (release_own) begin
          rr_ptr_d = owner_q + 2'd1;
          beat_d   = '0;
          if (found) owner_d = pick_idx;
          else       state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      beat_q    <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      q_id_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      beat_q    <= beat_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      q_id_q    <= q_id_d;
    end
  end

  assign bus.gnt_0_o   = (state_q == OWN) && (owner_q == 2'd0);
  assign bus.gnt_1_o   = (state_q == OWN) && (owner_q == 2'd1);
  assign bus.gnt_2_o   = (state_q == OWN) && (owner_q == 2'd2);
  assign bus.gnt_3_o   = (state_q == OWN) && (owner_q == 2'd3);
  assign bus.busy_o    = (state_q == OWN);
  assign bus.q_o       = q_q;
  assign bus.q_valid_o = q_valid_q;
  assign bus.q_id_o    = q_id_q;

endmodule

// File: tb/tb_pmux_rr_arbiter.sv
// Self-checking bench for pmux_rr_arbiter: behavioural reference model,
// per-cycle output comparison, directed scenarios with literal expectations,
// then randomized traffic with occasional resets.
module tb_pmux_rr_arbiter;

  localparam int W  = 16;
  localparam int BR = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] tb_req = '0;
  logic [2:0] tb_src  [4];
  logic [W-1:0] tb_data [8];

  always #5 clk = ~clk;

  pmux_rr_arbiter_if #(.WIDTH(W)) bus ();

  assign bus.req_0_i  = tb_req[0];
  assign bus.req_1_i  = tb_req[1];
  assign bus.req_2_i  = tb_req[2];
  assign bus.req_3_i  = tb_req[3];
  assign bus.src_0_i  = tb_src[0];
  assign bus.src_1_i  = tb_src[1];
  assign bus.src_2_i  = tb_src[2];
  assign bus.src_3_i  = tb_src[3];
  assign bus.data_0_i = tb_data[0];
  assign bus.data_1_i = tb_data[1];
  assign bus.data_2_i = tb_data[2];
  assign bus.data_3_i = tb_data[3];
  assign bus.data_4_i = tb_data[4];
  assign bus.data_5_i = tb_data[5];
  assign bus.data_6_i = tb_data[6];
  assign bus.data_7_i = tb_data[7];

  pmux_rr_arbiter #(.WIDTH(W), .BURST(BR)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model state: owner < 0 means nobody holds the mux.
  int m_owner = -1;
  int m_rr    = 0;
  int m_beats = 0;
  int e_gnt = 0, e_q = 0, e_qv = 0, e_qid = 0, e_busy = 0;

  // Logs of observed DUT behaviour for the literal checks.
  int vlog[$];
  int glog[$];
  int qlog[$];
  int idlog[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_seq(input string nm, input int got[$], input int exp[$]);
    chk({nm, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", nm, i), got[i], exp[i]);
  endtask

  function automatic int pick(input logic [3:0] r, input int ptr);
    for (int i = 0; i < 4; i++) begin
      if (r[(ptr + i) % 4]) return (ptr + i) % 4;
    end
    return -1;
  endfunction

  // One clock of the arbitration rules, evaluated on the inputs present at the edge.
  task automatic model_update();
    int p;
    bit rel;
    if (rst) begin
      m_owner = -1; m_rr = 0; m_beats = 0;
      e_q = 0; e_qv = 0; e_qid = 0;
    end else begin
      e_qv = 0;
      if (m_owner < 0) begin
        p = pick(tb_req, m_rr);
        if (p >= 0) begin m_owner = p; m_beats = 0; end
      end else begin
        rel = 0;
        if (!tb_req[m_owner]) rel = 1;
        else begin
          e_q   = int'(tb_data[tb_src[m_owner]]);
          e_qid = m_owner;
          e_qv  = 1;
          m_beats++;
          if (m_beats == BR) rel = 1;
        end
        if (rel) begin
          m_rr = (m_owner + 1) % 4;
          m_beats = 0;
          m_owner = pick(tb_req, m_rr);
        end
      end
    end
    e_gnt  = (m_owner >= 0) ? (1 << m_owner) : 0;
    e_busy = (m_owner >= 0) ? 1 : 0;
  endtask

  always @(negedge clk) begin
    logic [3:0] ag;
    ag = {bus.gnt_3_o, bus.gnt_2_o, bus.gnt_1_o, bus.gnt_0_o};
    if (chk_en) begin
      chk("gnt", ag, e_gnt);
      chk("busy", bus.busy_o, e_busy);
      chk("q_valid", bus.q_valid_o, e_qv);
      chk("q", bus.q_o, e_q);
      chk("q_id", bus.q_id_o, e_qid);
    end
    vlog.push_back(int'(bus.q_valid_o));
    glog.push_back(int'(ag));
    if (bus.q_valid_o === 1'b1) begin
      qlog.push_back(int'(bus.q_o));
      idlog.push_back(int'(bus.q_id_o));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    vlog.delete(); glog.delete(); qlog.delete(); idlog.delete();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic set_data(input int base, input int mul);
    for (int k = 0; k < 8; k++) tb_data[k] = W'(base + mul * k);
  endtask

  initial begin
    int e[$];
    for (int k = 0; k < 4; k++) tb_src[k] = '0;
    set_data(100, 1);

    // Reset for two cycles, then a single requester.
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_q", bus.q_o, 0);
    chk("rst_qv", bus.q_valid_o, 0);
    chk("rst_gnt", {bus.gnt_3_o, bus.gnt_2_o, bus.gnt_1_o, bus.gnt_0_o}, 0);

    tb_req = 4'b0100; tb_src[2] = 3'd5;
    clear_logs();
    repeat (10) tick();
    e = '{0,1,1,1,1,1,1,1,1,1};
    chk_seq("s1_valid", vlog, e);
    chk("s1_gnt_first", glog[0], 4);
    chk("s1_q", qlog[0], 105);
    chk("s1_id", idlog[0], 2);
    tb_req = '0;
    repeat (2) tick();

    // All four requesting from reset.
    do_reset(1);
    tb_req = 4'hF;
    for (int k = 0; k < 4; k++) tb_src[k] = 3'(k);
    clear_logs();
    repeat (18) tick();
    e = '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1};
    chk_seq("s2_valid", vlog, e);
    e = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
    chk_seq("s2_id", idlog, e);
    chk("s2_q5", qlog[5], 101);
    tb_req = '0;
    repeat (2) tick();

    // Early release by owner 1 with requester 3 waiting.
    do_reset(1);
    tb_src[1] = 3'd2; tb_src[3] = 3'd6;
    tb_req = 4'b1010;
    clear_logs();
    repeat (3) tick();
    tb_req[1] = 1'b0;
    repeat (3) tick();
    e = '{0,1,1,0,1,1};
    chk_seq("s3_valid", vlog, e);
    e = '{1,1,3,3};
    chk_seq("s3_id", idlog, e);
    e = '{102,102,106,106};
    chk_seq("s3_q", qlog, e);
    chk("s3_gnt_e3", glog[2], 2);
    chk("s3_gnt_e4", glog[3], 8);
    tb_req = '0;
    repeat (2) tick();

    // Per-beat source change.
    do_reset(1);
    set_data(0, 10);
    tb_req = 4'b0001; tb_src[0] = 3'd7;
    clear_logs();
    tick(); tick();
    tb_src[0] = 3'd0; tick();
    tb_src[0] = 3'd3; tick(); tick();
    e = '{70,0,30,30};
    chk_seq("s4_q", qlog, e);
    tb_req = '0;
    repeat (2) tick();

    // Reset mid-burst.
    do_reset(1);
    set_data(100, 1);
    tb_req = 4'b0100; tb_src[2] = 3'd1; tb_src[1] = 3'd4;
    clear_logs();
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("s5_gnt", {bus.gnt_3_o, bus.gnt_2_o, bus.gnt_1_o, bus.gnt_0_o}, 0);
    chk("s5_qv", bus.q_valid_o, 0);
    chk("s5_q", bus.q_o, 0);
    chk("s5_busy", bus.busy_o, 0);
    rst = 1'b0;
    tb_req = 4'b0110;
    tick();
    chk("s5_gnt_after", {bus.gnt_3_o, bus.gnt_2_o, bus.gnt_1_o, bus.gnt_0_o}, 2);
    tb_req = '0;
    repeat (2) tick();

    // Rotation wrapping from 3 to 0, then 2.
    do_reset(1);
    tb_src[3] = 3'd3; tb_src[0] = 3'd0; tb_src[2] = 3'd2;
    tb_req = 4'b1000;
    clear_logs();
    tick();
    tb_req = 4'b1101;
    repeat (9) tick();
    e = '{3,3,3,3,0,0,0,0,2};
    chk_seq("s6_id", idlog, e);
    tb_req = '0;
    repeat (2) tick();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (!tb_req[k]) tb_req[k] = ($urandom_range(0, 99) < 30);
        else if ($urandom_range(0, 99) < 15) tb_req[k] = 1'b0;
        tb_src[k] = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 3) == 0)
        for (int k = 0; k < 8; k++) tb_data[k] = W'($urandom);
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;
    tb_req = '0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
